// File: rtl/tmu2_pkg.sv
// rtl/tmu2_pkg.sv - shared constants and packed-channel helper for the TMU2 hdivops stage
package tmu2_pkg;

  localparam int NCH_DEF = 2;
  localparam int TW_DEF  = 18;
  localparam int XW_DEF  = 12;

  // LSB position of channel k inside a packed NCH*tw vector
  function automatic int chan_lsb(input int k, input int tw);
    return k * tw;
  endfunction

endpackage

// File: rtl/tmu2_hdivops_mc_if.sv
// rtl/tmu2_hdivops_mc_if.sv - stb/ack pipeline bus into and out of tmu2_hdivops_mc
interface tmu2_hdivops_mc_if
  import tmu2_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int TW  = TW_DEF,
  parameter int XW  = XW_DEF
);

  logic                pipe_stb_i;
  logic                pipe_ack_o;
  logic [XW-1:0]       x;
  logic [XW-1:0]       y;
  logic [NCH*TW-1:0]   ts;
  logic [NCH*TW-1:0]   te;
  logic                pipe_stb_o;
  logic                pipe_ack_i;
  logic [XW-1:0]       x_f;
  logic [XW-1:0]       y_f;
  logic [NCH*TW-1:0]   ts_f;
  logic [NCH-1:0]      diff_positive;
  logic [NCH*TW-1:0]   diff;
  logic [NCH-1:0]      diff_zero;

  modport slave (
    input  pipe_stb_i, x, y, ts, te, pipe_ack_i,
    output pipe_ack_o, pipe_stb_o, x_f, y_f, ts_f, diff_positive, diff, diff_zero
  );

  modport master (
    output pipe_stb_i, x, y, ts, te, pipe_ack_i,
    input  pipe_ack_o, pipe_stb_o, x_f, y_f, ts_f, diff_positive, diff, diff_zero
  );

endinterface

// File: rtl/tmu2_hdivops_chan.sv
// rtl/tmu2_hdivops_chan.sv - one coordinate channel: compare and subtract in S1, magnitude select in S2
module tmu2_hdivops_chan
  import tmu2_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s1_load,
  input  logic          s2_load,
  input  logic [TW-1:0] ts,
  input  logic [TW-1:0] te,
  output logic          diff_positive,
  output logic [TW-1:0] diff,
  output logic          diff_zero
);

  logic          gt_q, gt_d;
  logic [TW:0]   dpos_q, dpos_d;
  logic [TW:0]   dneg_q, dneg_d;
  logic          dp_q, dp_d;
  logic [TW-1:0] diff_q, diff_d;
  logic          dz_q, dz_d;
  logic [TW:0]   mag;

  always_comb begin
    gt_d   = gt_q;
    dpos_d = dpos_q;
    dneg_d = dneg_q;
    dp_d   = dp_q;
    diff_d = diff_q;
    dz_d   = dz_q;
    // TW+1 bits hold any difference of two TW-bit signed values without overflow
    mag    = gt_q ? dpos_q : dneg_q;
    if (s1_load) begin
      gt_d   = $signed(te) > $signed(ts);
      dpos_d = {te[TW-1], te} - {ts[TW-1], ts};
      dneg_d = {ts[TW-1], ts} - {te[TW-1], te};
    end
    if (s2_load) begin
      dp_d   = gt_q;
      diff_d = mag[TW-1:0];
      dz_d   = (mag == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_q   <= 1'b0;
      dpos_q <= '0;
      dneg_q <= '0;
      dp_q   <= 1'b0;
      diff_q <= '0;
      dz_q   <= 1'b0;
    end else begin
      gt_q   <= gt_d;
      dpos_q <= dpos_d;
      dneg_q <= dneg_d;
      dp_q   <= dp_d;
      diff_q <= diff_d;
      dz_q   <= dz_d;
    end
  end

  assign diff_positive = dp_q;
  assign diff          = diff_q;
  assign diff_zero     = dz_q;

endmodule

// File: rtl/tmu2_hdivops_mc.sv
// rtl/tmu2_hdivops_mc.sv - multi-channel hdivops operand stage; TMU2_HDIVOPS_STATS_EN adds delivery counters
module tmu2_hdivops_mc
  import tmu2_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int TW  = TW_DEF,
  parameter int XW  = XW_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  tmu2_hdivops_mc_if.slave   bus,
  output logic               busy
`ifdef TMU2_HDIVOPS_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [31:0]        vertex_count,
  output logic [31:0]        zero_count
`endif
);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [XW-1:0]     x_s1_q, x_s1_d, y_s1_q, y_s1_d;
  logic [NCH*TW-1:0] ts_s1_q, ts_s1_d;
  logic [XW-1:0]     x_f_q, x_f_d, y_f_q, y_f_d;
  logic [NCH*TW-1:0] ts_f_q, ts_f_d;
  logic              s2_free, s1_adv, accept;

  // Accept and advance may coincide, so a full pipe still moves one vertex per cycle
  always_comb begin
    s2_free    = ~s2_valid_q | bus.pipe_ack_i;
    s1_adv     = s1_valid_q & s2_free;
    accept     = bus.pipe_stb_i & (~s1_valid_q | s2_free);
    s1_valid_d = accept | (s1_valid_q & ~s2_free);
    s2_valid_d = s1_adv | (s2_valid_q & ~bus.pipe_ack_i);
    x_s1_d     = accept ? bus.x  : x_s1_q;
    y_s1_d     = accept ? bus.y  : y_s1_q;
    ts_s1_d    = accept ? bus.ts : ts_s1_q;
    x_f_d      = s1_adv ? x_s1_q  : x_f_q;
    y_f_d      = s1_adv ? y_s1_q  : y_f_q;
    ts_f_d     = s1_adv ? ts_s1_q : ts_f_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      x_s1_q     <= '0;
      y_s1_q     <= '0;
      ts_s1_q    <= '0;
      x_f_q      <= '0;
      y_f_q      <= '0;
      ts_f_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      x_s1_q     <= x_s1_d;
      y_s1_q     <= y_s1_d;
      ts_s1_q    <= ts_s1_d;
      x_f_q      <= x_f_d;
      y_f_q      <= y_f_d;
      ts_f_q     <= ts_f_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    localparam int LSB = chan_lsb(k, TW);
    tmu2_hdivops_chan #(.TW(TW)) u_chan (
      .clk           (sys_clk),
      .rst_n         (sys_rst_n),
      .s1_load       (accept),
      .s2_load       (s1_adv),
      .ts            (bus.ts[LSB +: TW]),
      .te            (bus.te[LSB +: TW]),
      .diff_positive (bus.diff_positive[k]),
      .diff          (bus.diff[LSB +: TW]),
      .diff_zero     (bus.diff_zero[k])
    );
  end

  assign bus.pipe_ack_o = ~s1_valid_q | s2_free;
  assign bus.pipe_stb_o = s2_valid_q;
  assign bus.x_f        = x_f_q;
  assign bus.y_f        = y_f_q;
  assign bus.ts_f       = ts_f_q;
  assign busy           = s1_valid_q | s2_valid_q;

`ifdef TMU2_HDIVOPS_STATS_EN
  logic [31:0] vcnt_q, vcnt_d, zcnt_q, zcnt_d;
  logic        deliver;

  // Counters saturate; clear wins over a coincident delivery
  always_comb begin
    deliver = s2_valid_q & bus.pipe_ack_i;
    vcnt_d  = vcnt_q;
    zcnt_d  = zcnt_q;
    if (stats_clr) begin
      vcnt_d = '0;
      zcnt_d = '0;
    end else if (deliver) begin
      if (vcnt_q != '1) vcnt_d = vcnt_q + 32'd1;
      if ((|bus.diff_zero) && (zcnt_q != '1)) zcnt_d = zcnt_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vcnt_q <= '0;
      zcnt_q <= '0;
    end else begin
      vcnt_q <= vcnt_d;
      zcnt_q <= zcnt_d;
    end
  end

  assign vertex_count = vcnt_q;
  assign zero_count   = zcnt_q;
`endif

endmodule

// File: tb/tb_tmu2_hdivops_mc.sv
// tb/tb_tmu2_hdivops_mc.sv - directed self-checking bench for tmu2_hdivops_mc (NCH=2, TW=18, XW=12)
module tb_tmu2_hdivops_mc;

  localparam int NCH = 2;
  localparam int TW  = 18;
  localparam int XW  = 12;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic busy;
`ifdef TMU2_HDIVOPS_STATS_EN
  logic        stats_clr;
  logic [31:0] vertex_count;
  logic [31:0] zero_count;
`endif

  int checks   = 0;
  int failures = 0;

  tmu2_hdivops_mc_if #(.NCH(NCH), .TW(TW), .XW(XW)) bus ();

  tmu2_hdivops_mc #(.NCH(NCH), .TW(TW), .XW(XW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave),
    .busy      (busy)
`ifdef TMU2_HDIVOPS_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .vertex_count (vertex_count),
    .zero_count   (zero_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ts0, input int te0, input int ts1, input int te1,
                       input int xv, input int yv);
    bus.ts = {ts1[TW-1:0], ts0[TW-1:0]};
    bus.te = {te1[TW-1:0], te0[TW-1:0]};
    bus.x  = xv[XW-1:0];
    bus.y  = yv[XW-1:0];
  endtask

  // Sends one vertex into an empty pipe with ack held high and checks latency and results
  task automatic run_vertex(input string tag, input int ts0, input int te0, input int ts1,
                            input int te1, input int xv, input int yv, input int e_pos,
                            input int e_d0, input int e_d1, input int e_zero);
    logic [NCH*TW-1:0] e_diff;
    logic [NCH*TW-1:0] e_ts;
    e_diff = {e_d1[TW-1:0], e_d0[TW-1:0]};
    e_ts   = {ts1[TW-1:0], ts0[TW-1:0]};
    @(posedge sys_clk); #1;
    bus.pipe_ack_i = 1'b1;
    bus.pipe_stb_i = 1'b1;
    drive(ts0, te0, ts1, te1, xv, yv);
    @(posedge sys_clk); #1;
    bus.pipe_stb_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk({tag, "_lat1_stb"}, 64'(bus.pipe_stb_o), 64'd0);
    chk({tag, "_lat1_busy"}, 64'(busy), 64'd1);
    @(posedge sys_clk); #1;
    chk({tag, "_stb"}, 64'(bus.pipe_stb_o), 64'd1);
    chk({tag, "_pos"}, 64'(bus.diff_positive), 64'(e_pos));
    chk({tag, "_diff"}, 64'(bus.diff), 64'(e_diff));
    chk({tag, "_zero"}, 64'(bus.diff_zero), 64'(e_zero));
    chk({tag, "_xf"}, 64'(bus.x_f), 64'(xv[XW-1:0]));
    chk({tag, "_yf"}, 64'(bus.y_f), 64'(yv[XW-1:0]));
    chk({tag, "_tsf"}, 64'(bus.ts_f), 64'(e_ts));
    @(posedge sys_clk); #1;
    chk({tag, "_drain"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int in_idx;
    int out_idx;
    int inflight;
    int cyc;
    bit acc;
    bit del;
    bit prev_stall;
    logic [XW-1:0]     held_x;
    logic [NCH*TW-1:0] held_diff;
    int d1v;
    int d0v;
    logic [NCH*TW-1:0] e_diff;

    sys_rst_n      = 1'b0;
    bus.pipe_stb_i = 1'b0;
    bus.pipe_ack_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
`ifdef TMU2_HDIVOPS_STATS_EN
    stats_clr = 1'b0;
`endif
    #12;
    chk("rst_stb", 64'(bus.pipe_stb_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_diff", 64'(bus.diff), 64'd0);
    chk("rst_xf", 64'(bus.x_f), 64'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    #1;
    chk("rst_ack", 64'(bus.pipe_ack_o), 64'd1);

    run_vertex("vA", 100, 300, -50, -200, 5, -3, 1, 200, 150, 0);
    run_vertex("vB", 7, 7, 0, 5, 1, 2, 2, 0, 5, 1);
    run_vertex("vC", -131072, 131071, 131071, -131072, -2048, 2047, 1, 262143, 262143, 0);

    // Streaming with ack pattern 1,0,0,1; upstream always offers the next vertex
    in_idx = 0; out_idx = 0; inflight = 0; prev_stall = 0;
    held_x = '0; held_diff = '0;
    for (cyc = 0; cyc < 80 && out_idx < 10; cyc++) begin
      @(posedge sys_clk); #1;
      bus.pipe_ack_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      bus.pipe_stb_i = (in_idx < 10);
      drive(10 * in_idx, (in_idx % 2 == 0) ? 10 * in_idx + 3 : 10 * in_idx - 3,
            -in_idx, in_idx, in_idx + 1, 100 + in_idx);
      @(negedge sys_clk);
      chk("st_ack_o", 64'(bus.pipe_ack_o), 64'(!(inflight == 2 && !bus.pipe_ack_i)));
      if (prev_stall) begin
        chk("st_hold_x", 64'(bus.x_f), 64'(held_x));
        chk("st_hold_diff", 64'(bus.diff), 64'(held_diff));
      end
      acc = bus.pipe_stb_i && bus.pipe_ack_o;
      del = bus.pipe_stb_o && bus.pipe_ack_i;
      if (del) begin
        d0v = 3;
        d1v = 2 * out_idx;
        e_diff = {d1v[TW-1:0], d0v[TW-1:0]};
        chk("st_xf", 64'(bus.x_f), 64'(out_idx + 1));
        chk("st_diff", 64'(bus.diff), 64'(e_diff));
        chk("st_pos", 64'(bus.diff_positive),
            64'({out_idx > 0, out_idx % 2 == 0}));
        chk("st_zero", 64'(bus.diff_zero), 64'({out_idx == 0, 1'b0}));
        out_idx++;
      end
      prev_stall = bus.pipe_stb_o && !bus.pipe_ack_i;
      held_x     = bus.x_f;
      held_diff  = bus.diff;
      if (acc) in_idx++;
      inflight = inflight + int'(acc) - int'(del);
    end
    chk("st_count", 64'(out_idx), 64'd10);
    @(posedge sys_clk); #1;
    bus.pipe_stb_i = 1'b0;
    bus.pipe_ack_i = 1'b1;
    @(posedge sys_clk); #1;
    chk("st_drain", 64'(busy), 64'd0);

    // Fill both stages under stall, then reset asynchronously mid-cycle
    bus.pipe_ack_i = 1'b0;
    bus.pipe_stb_i = 1'b1;
    drive(1, 2, 3, 4, 9, 9);
    @(posedge sys_clk); #1;
    drive(5, 6, 7, 8, 10, 10);
    @(posedge sys_clk); #1;
    bus.pipe_stb_i = 1'b0;
    chk("full_ack_o", 64'(bus.pipe_ack_o), 64'd0);
    chk("full_stb", 64'(bus.pipe_stb_o), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_stb", 64'(bus.pipe_stb_o), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_diff", 64'(bus.diff), 64'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    #1;
    chk("arst_ack", 64'(bus.pipe_ack_o), 64'd1);
    run_vertex("vD", -1, -1, -1, -1, 3, 4, 0, 0, 0, 3);

`ifdef TMU2_HDIVOPS_STATS_EN
    @(posedge sys_clk); #1;
    stats_clr = 1'b1;
    @(posedge sys_clk); #1;
    stats_clr = 1'b0;
    chk("stat_clr0", 64'(vertex_count), 64'd0);
    run_vertex("sA", 100, 300, -50, -200, 5, -3, 1, 200, 150, 0);
    run_vertex("sB", 7, 7, 0, 5, 1, 2, 2, 0, 5, 1);
    run_vertex("sC", -131072, 131071, 131071, -131072, -2048, 2047, 1, 262143, 262143, 0);
    run_vertex("sD", -1, -1, -1, -1, 3, 4, 0, 0, 0, 3);
    run_vertex("sE", 100, 300, -50, -200, 5, -3, 1, 200, 150, 0);
    chk("stat_vcnt", 64'(vertex_count), 64'd5);
    chk("stat_zcnt", 64'(zero_count), 64'd2);
    @(posedge sys_clk); #1;
    bus.pipe_stb_i = 1'b1;
    drive(7, 7, 7, 7, 0, 0);
    @(posedge sys_clk); #1;
    bus.pipe_stb_i = 1'b0;
    @(posedge sys_clk); #1;
    chk("stat_pre_stb", 64'(bus.pipe_stb_o), 64'd1);
    stats_clr = 1'b1;
    @(posedge sys_clk); #1;
    stats_clr = 1'b0;
    chk("stat_clr_v", 64'(vertex_count), 64'd0);
    chk("stat_clr_z", 64'(zero_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
